ram_be_clr: RTL and testbench

Single-clock simple dual-port RAM with per-byte write enables, selectable read-during-write behaviour, selectable read latency and a hardware clear engine. It is the parametrised successor to the team's basic 1R/1W memory. It serves as the storage primitive for buffers and lookup tables that need deterministic contents after reset and partial-word updates.

---
 rtl/ram_pkg.sv | 26 ++
 rtl/ram_rd_pipe.sv | 64 ++++++
 rtl/ram_be_clr.sv | 147 ++++++++++++++
 tb/tb_ram_be_clr.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_pkg
// Purpose  : Shared types, bounds and the byte-lane merge helper for ram_be_clr.
// Revision : 1.0 - initial release
// ============================================================================
package ram_pkg;

   typedef enum logic [0:0] {
      RAM_CLEAR = 1'b0,
      RAM_IDLE  = 1'b1
   } ram_state_t;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   function automatic logic [7:0] byte_merge(
      input logic [7:0] old_byte,
      input logic [7:0] new_byte,
      input logic       be
   );
      return be ? new_byte : old_byte;
   endfunction

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ram_rd_pipe
// Purpose  : Data+valid delay line of STAGES registers with sync active-low flush.
// Revision : 1.0 - initial release
// ============================================================================
module ram_rd_pipe #(
   parameter int D_WIDTH = 16,
   parameter int STAGES  = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [D_WIDTH-1:0] in_data,
   output logic               out_valid,
   output logic [D_WIDTH-1:0] out_data
);

   if (STAGES == 0) begin : g_pass
      logic unused_pass;
      assign unused_pass = ^{clk, rst_n};
      assign out_valid   = in_valid;
      assign out_data    = in_data;
   end else begin : g_stage
      logic [STAGES-1:0]  valid_q, valid_d;
      logic [D_WIDTH-1:0] data_q [STAGES];
      logic [D_WIDTH-1:0] data_d [STAGES];
      logic [STAGES:0]    v_chain;
      logic [D_WIDTH-1:0] d_chain [STAGES+1];

      // Data only advances with a valid beat so the output holds between reads.
      always_comb begin
         v_chain[0] = in_valid;
         d_chain[0] = in_data;
         for (int s = 0; s < STAGES; s++) begin
            v_chain[s+1] = valid_q[s];
            d_chain[s+1] = data_q[s];
         end
         for (int s = 0; s < STAGES; s++) begin
            valid_d[s] = v_chain[s];
            data_d[s]  = v_chain[s] ? d_chain[s] : data_q[s];
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            valid_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
               data_q[s] <= '0;
            end
         end else begin
            valid_q <= valid_d;
            for (int s = 0; s < STAGES; s++) begin
               data_q[s] <= data_d[s];
            end
         end
      end

      assign out_valid = v_chain[STAGES];
      assign out_data  = d_chain[STAGES];
   end

endmodule : ram_rd_pipe
`default_nettype wire

// File: rtl/ram_be_clr.sv
`default_nettype none
// ============================================================================
// Module   : ram_be_clr
// Purpose  : 1R/1W RAM with byte enables, selectable bypass/latency and a clear engine.
// Revision : 1.0 - initial release
// ============================================================================
module ram_be_clr
   import ram_pkg::*;
#(
   parameter int D_WIDTH      = 16,
   parameter int A_WIDTH      = 4,
   parameter int READ_LATENCY = 1,
   parameter int BYPASS       = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   write_enable,
   input  logic [D_WIDTH/8-1:0]   byte_enable,
   input  logic [A_WIDTH-1:0]     address_write,
   input  logic [D_WIDTH-1:0]     data_write,
   input  logic                   read_enable,
   input  logic [A_WIDTH-1:0]     address_read,
   output logic [D_WIDTH-1:0]     data_read,
   output logic                   read_valid,
   input  logic                   clear_start,
   output logic                   busy
);

   localparam int NB    = D_WIDTH / 8;
   localparam int DEPTH = 2 ** A_WIDTH;
   localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(DEPTH - 1);

   if (D_WIDTH % 8 != 0) begin : g_chk_dwidth
      $error("ram_be_clr: D_WIDTH must be a multiple of 8");
   end
   if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_chk_lat
      $error("ram_be_clr: READ_LATENCY must be 1 or 2");
   end
   if (BYPASS != 0 && BYPASS != 1) begin : g_chk_bypass
      $error("ram_be_clr: BYPASS must be 0 or 1");
   end

   ram_state_t         state_q, state_d;
   logic [A_WIDTH-1:0] clr_addr_q, clr_addr_d;
   logic               rd_valid_q, rd_valid_d;
   logic [D_WIDTH-1:0] rd_data_q, rd_data_d;
   logic [D_WIDTH-1:0] mem_q [DEPTH];

   logic               wr_en;
   logic [A_WIDTH-1:0] wr_addr;
   logic [D_WIDTH-1:0] wr_data;
   logic [D_WIDTH-1:0] old_word;
   logic [D_WIDTH-1:0] merged_word;
   logic [D_WIDTH-1:0] rd_word;
   logic               rd_accept;
   logic               user_wr;

   assign old_word = mem_q[address_write];

   for (genvar i = 0; i < NB; i++) begin : g_lane
      assign merged_word[8*i +: 8] = byte_merge(old_word[8*i +: 8],
                                                data_write[8*i +: 8],
                                                byte_enable[i]);
   end

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      wr_en      = 1'b0;
      wr_addr    = address_write;
      wr_data    = merged_word;
      rd_accept  = 1'b0;
      user_wr    = 1'b0;
      case (state_q)
         RAM_CLEAR: begin
            wr_en      = 1'b1;
            wr_addr    = clr_addr_q;
            wr_data    = '0;
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == LAST_ADDR) begin
               state_d = RAM_IDLE;
            end
         end
         RAM_IDLE: begin
            rd_accept = read_enable;
            // Clear wins over a same-cycle write; the read still sees pre-clear data.
            if (clear_start) begin
               state_d    = RAM_CLEAR;
               clr_addr_d = '0;
            end else begin
               user_wr = write_enable;
               wr_en   = write_enable;
            end
         end
         default: begin
            state_d    = RAM_CLEAR;
            clr_addr_d = '0;
         end
      endcase
   end

   always_comb begin
      rd_word = mem_q[address_read];
      if (BYPASS == 1 && user_wr && (address_write == address_read)) begin
         rd_word = merged_word;
      end
      rd_valid_d = rd_accept;
      rd_data_d  = rd_accept ? rd_word : rd_data_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= RAM_CLEAR;
         clr_addr_q <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Storage is not reset; the sweep following reset zeroes it.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign busy = (state_q == RAM_CLEAR);

   ram_rd_pipe #(
      .D_WIDTH (D_WIDTH),
      .STAGES  (READ_LATENCY - 1)
   ) u_rd_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (rd_valid_q),
      .in_data   (rd_data_q),
      .out_valid (read_valid),
      .out_data  (data_read)
   );

endmodule : ram_be_clr
`default_nettype wire

// File: tb/tb_ram_be_clr.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_be_clr
// Purpose  : Self-checking bench: two builds (lat1/write-first, lat2/read-first).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_be_clr;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        write_enable;
   logic [1:0]  byte_enable;
   logic [3:0]  address_write;
   logic [15:0] data_write;
   logic        read_enable;
   logic [3:0]  address_read;
   logic        clear_start;

   logic [15:0] dr_a, dr_b;
   logic        rv_a, rv_b;
   logic        busy_a, busy_b;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   ram_be_clr #(.D_WIDTH(16), .A_WIDTH(4), .READ_LATENCY(1), .BYPASS(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .write_enable(write_enable), .byte_enable(byte_enable),
      .address_write(address_write), .data_write(data_write), .read_enable(read_enable),
      .address_read(address_read), .data_read(dr_a), .read_valid(rv_a),
      .clear_start(clear_start), .busy(busy_a)
   );

   ram_be_clr #(.D_WIDTH(16), .A_WIDTH(4), .READ_LATENCY(2), .BYPASS(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .write_enable(write_enable), .byte_enable(byte_enable),
      .address_write(address_write), .data_write(data_write), .read_enable(read_enable),
      .address_read(address_read), .data_read(dr_b), .read_valid(rv_b),
      .clear_start(clear_start), .busy(busy_b)
   );

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
   endtask

   function automatic logic [15:0] merge16(input logic [15:0] o, input logic [15:0] n,
                                           input logic [1:0] be);
      return {be[1] ? n[15:8] : o[15:8], be[0] ? n[7:0] : o[7:0]};
   endfunction

   // ---------------- behavioural model: index 0 = build A, 1 = build B --------
   logic [15:0] m_mem   [2][16];
   int          m_left  [2];
   logic        m_vout  [2];
   logic [15:0] m_dout  [2];
   logic        m_pv    [2];
   logic [15:0] m_pd    [2];
   int          m_lat   [2] = '{1, 2};
   int          m_byp   [2] = '{1, 0};
   bit          seen_rst = 1'b0;

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         logic        ev;
         logic [15:0] ed;
         logic [15:0] nw;
         ev = 1'b0;
         ed = '0;
         if (!rst_n) begin
            seen_rst  = 1'b1;
            m_left[k] = 16;
            m_pv[k]   = 1'b0;
            m_pd[k]   = '0;
            m_vout[k] = 1'b0;
            m_dout[k] = '0;
         end else begin
            if (m_left[k] > 0) begin
               m_mem[k][16 - m_left[k]] = '0;
               m_left[k]--;
            end else begin
               if (read_enable) begin
                  ev = 1'b1;
                  ed = m_mem[k][address_read];
               end
               if (clear_start) begin
                  m_left[k] = 16;
               end else if (write_enable) begin
                  nw = merge16(m_mem[k][address_write], data_write, byte_enable);
                  if (read_enable && address_read == address_write && m_byp[k] == 1) ed = nw;
                  m_mem[k][address_write] = nw;
               end
            end
            if (m_lat[k] == 1) begin
               m_vout[k] = ev;
               if (ev) m_dout[k] = ed;
            end else begin
               m_vout[k] = m_pv[k];
               if (m_pv[k]) m_dout[k] = m_pd[k];
               m_pv[k] = ev;
               m_pd[k] = ed;
            end
         end
      end
   end

   // ---------------- per-cycle compare against the model ---------------------
   always @(negedge clk) begin
      if (seen_rst) begin
         chk("a_busy",  {15'd0, busy_a}, {15'd0, m_left[0] > 0});
         chk("a_valid", {15'd0, rv_a},   {15'd0, m_vout[0]});
         chk("a_data",  dr_a,            m_dout[0]);
         chk("b_busy",  {15'd0, busy_b}, {15'd0, m_left[1] > 0});
         chk("b_valid", {15'd0, rv_b},   {15'd0, m_vout[1]});
         chk("b_data",  dr_b,            m_dout[1]);
      end
   end

   // ---------------- directed helpers ----------------------------------------
   task automatic idle_inputs();
      write_enable = 1'b0; byte_enable = 2'b00; address_write = '0; data_write = '0;
      read_enable = 1'b0; address_read = '0; clear_start = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
      write_enable = 1'b1; address_write = a; data_write = d; byte_enable = be;
      @(negedge clk);
      write_enable = 1'b0; byte_enable = 2'b00;
   endtask

   task automatic read_check(input string name, input logic [3:0] a,
                             input logic [15:0] exp_a, input logic [15:0] exp_b);
      read_enable = 1'b1; address_read = a;
      @(negedge clk);
      read_enable = 1'b0;
      chk({name, "_va"}, {15'd0, rv_a}, 16'd1);
      chk({name, "_da"}, dr_a, exp_a);
      @(negedge clk);
      chk({name, "_vb"}, {15'd0, rv_b}, 16'd1);
      chk({name, "_db"}, dr_b, exp_b);
   endtask

   // Counts negedges (including the current one) at which busy is high.
   task automatic wait_busy(output int n);
      n = 0;
      while (busy_a && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_busy", {15'd0, busy_a}, 16'd1);
      chk("rst_dout", dr_a, 16'h0000);
      wait_busy(n);
      chk("rst_busy_len", 16'(n), 16'd16);
      for (int a = 0; a < 16; a++) read_check("clr_rd", 4'(a), 16'h0000, 16'h0000);

      // byte enables
      wr(4'd3, 16'hABCD, 2'b11);
      wr(4'd3, 16'h1234, 2'b01);
      read_check("be_rd", 4'd3, 16'hAB34, 16'hAB34);
      wr(4'd3, 16'h5555, 2'b00);
      read_check("be0_rd", 4'd3, 16'hAB34, 16'hAB34);

      // collision
      wr(4'd5, 16'h1111, 2'b11);
      write_enable = 1'b1; address_write = 4'd5; data_write = 16'h2222; byte_enable = 2'b10;
      read_enable = 1'b1; address_read = 4'd5;
      @(negedge clk);
      idle_inputs();
      chk("col_da", dr_a, 16'h2211);
      @(negedge clk);
      chk("col_db", dr_b, 16'h1111);
      read_check("col_after", 4'd5, 16'h2211, 16'h2211);

      // latency / back-to-back
      wr(4'd1, 16'h0101, 2'b11);
      wr(4'd2, 16'h0202, 2'b11);
      wr(4'd3, 16'h0303, 2'b11);
      read_enable = 1'b1; address_read = 4'd1;
      @(negedge clk);
      chk("lat_a1", dr_a, 16'h0101);
      chk("lat_vb0", {15'd0, rv_b}, 16'd0);
      address_read = 4'd2;
      @(negedge clk);
      chk("lat_a2", dr_a, 16'h0202);
      chk("lat_b1", dr_b, 16'h0101);
      chk("lat_vb1", {15'd0, rv_b}, 16'd1);
      address_read = 4'd3;
      @(negedge clk);
      chk("lat_b2", dr_b, 16'h0202);
      read_enable = 1'b0;
      @(negedge clk);
      chk("lat_va_end", {15'd0, rv_a}, 16'd0);
      chk("lat_b3", dr_b, 16'h0303);
      @(negedge clk);
      chk("lat_vb_end", {15'd0, rv_b}, 16'd0);
      chk("lat_hold_b", dr_b, 16'h0303);

      // clear mid-traffic
      for (int a = 0; a < 16; a++) wr(4'(a), 16'hFFFF, 2'b11);
      clear_start = 1'b1;
      write_enable = 1'b1; address_write = 4'd7; data_write = 16'h1234; byte_enable = 2'b11;
      read_enable = 1'b1; address_read = 4'd7;
      @(negedge clk);
      idle_inputs();
      chk("clr_pre_a", dr_a, 16'hFFFF);
      @(negedge clk);
      chk("clr_pre_b", dr_b, 16'hFFFF);
      wait_busy(n);
      chk("clr_busy_len", 16'(n + 1), 16'd16);
      for (int a = 0; a < 16; a++) read_check("clr2_rd", 4'(a), 16'h0000, 16'h0000);

      // reset mid-clear
      wr(4'd15, 16'hBEEF, 2'b11);
      wr(4'd2, 16'hCAFE, 2'b11);
      clear_start = 1'b1;
      @(negedge clk);
      clear_start = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_busy(n);
      chk("rstclr_busy_len", 16'(n), 16'd16);
      read_check("rstclr_rd15", 4'd15, 16'h0000, 16'h0000);
      read_check("rstclr_rd2", 4'd2, 16'h0000, 16'h0000);

      // randomized traffic checked by the model
      for (int c = 0; c < 3000; c++) begin
         write_enable  = 1'($urandom_range(0, 1));
         byte_enable   = 2'($urandom_range(0, 3));
         address_write = 4'($urandom_range(0, 15));
         data_write    = 16'($urandom);
         read_enable   = 1'($urandom_range(0, 1));
         address_read  = 4'($urandom_range(0, 15));
         clear_start   = ($urandom_range(0, 149) == 0);
         rst_n         = ($urandom_range(0, 399) != 0);
         @(negedge clk);
      end
      idle_inputs();
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_ram_be_clr
`default_nettype wire
